// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages.
//   DATA_W / REG_ADDR_W : datapath and register-number widths
//   load_mode_t         : sized-load selector carried from decode
//   mem_wb_t            : payload held in the MEM/WB pipeline register
//   access_misaligned() : alignment rule shared by loads and stores
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        LM_WORD  = 2'b00,
        LM_HALF  = 2'b01,
        LM_BYTE  = 2'b10,
        LM_BYTEU = 2'b11
    } load_mode_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     mem_data;
        logic [DATA_W-1:0]     alu_result;
    } mem_wb_t;

    // Stores are always full-word, so any store needs word alignment no
    // matter which load_mode accompanies it. Loads are checked by size;
    // byte loads can never be misaligned.
    function automatic logic access_misaligned(
        input load_mode_t mode,
        input logic [1:0] offset,
        input logic       mem_read,
        input logic       mem_write
    );
        logic load_bad;
        logic store_bad;
        store_bad = mem_write && (offset != 2'b00);
        case (mode)
            LM_WORD: load_bad = mem_read && (offset != 2'b00);
            LM_HALF: load_bad = mem_read && offset[0];
            default: load_bad = 1'b0;
        endcase
        return store_bad || load_bad;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: one stage, no stall/flush, updates every edge.
// Ports:
//   clk   : stage clock
//   reset : asynchronous active-high reset, clears the whole payload
//   d     : next MEM/WB payload from the memory stage
//   q     : registered payload towards write-back
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline.
// Holds the data memory (word-wide synchronous write, combinational read,
// big-endian sized loads), resolves beq-type branches and drives the
// MEM/WB register.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   in_*                       : EX/MEM register outputs (controls, ALU
//                                result/address, store data, branch target)
//   PCSrc_out, branch_pc_out   : combinational branch decision and target
//   RegWrite_out, MemToReg_out,
//   writebackDestination_out,
//   memData_out, aluResult_out : registered MEM/WB outputs
//   mem_fault                  : sticky misaligned-access flag
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_RegWrite,
    input  logic                  in_MemWrite,
    input  logic                  in_MemRead,
    input  logic                  in_MemToReg,
    input  logic                  in_Branch,
    input  logic [1:0]            in_load_mode,
    input  logic                  in_zero,
    input  logic [DATA_W-1:0]     in_aluResult,
    input  logic [DATA_W-1:0]     in_rt,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [REG_ADDR_W-1:0] in_writebackDestination,
    output logic                  PCSrc_out,
    output logic [DATA_W-1:0]     branch_pc_out,
    output logic                  RegWrite_out,
    output logic                  MemToReg_out,
    output logic [REG_ADDR_W-1:0] writebackDestination_out,
    output logic [DATA_W-1:0]     memData_out,
    output logic [DATA_W-1:0]     aluResult_out,
    output logic                  mem_fault
);

    // Upper address bits are dropped, so accesses wrap modulo DEPTH*4.
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           byte_off;
    load_mode_t           load_mode;
    logic                 misaligned;
    logic                 write_en;

    assign word_idx   = in_aluResult[ADDR_BITS+1:2];
    assign byte_off   = in_aluResult[1:0];
    assign load_mode  = load_mode_t'(in_load_mode);
    assign misaligned = access_misaligned(load_mode, byte_off, in_MemRead, in_MemWrite);
    assign write_en   = in_MemWrite && !misaligned;

    // Branch resolution is purely combinational and masked during reset.
    assign PCSrc_out     = in_Branch & in_zero & ~reset;
    assign branch_pc_out = in_pc;

    // Data memory. Contents survive reset; reset only blocks the write.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset && write_en) begin
            mem[word_idx] <= in_rt;
        end
    end

    // Read returns the pre-write value when a store hits the same cycle.
    logic [DATA_W-1:0] rd_word;
    assign rd_word = mem[word_idx];

    // Big-endian byte lanes: lane 0 is bits [31:24].
    logic [7:0] word_bytes [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign word_bytes[gi] = rd_word[DATA_W-1-8*gi -: 8];
    end

    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [DATA_W-1:0] load_result;

    always_comb begin
        half_sel    = byte_off[1] ? rd_word[15:0] : rd_word[31:16];
        byte_sel    = word_bytes[byte_off];
        load_result = rd_word;
        case (load_mode)
            LM_WORD:  load_result = rd_word;
            LM_HALF:  load_result = {{16{half_sel[15]}}, half_sel};
            LM_BYTE:  load_result = {{24{byte_sel[7]}}, byte_sel};
            LM_BYTEU: load_result = {24'd0, byte_sel};
            default:  load_result = rd_word;
        endcase
        if (misaligned) begin
            load_result = '0;
        end
    end

    // MEM/WB payload; a faulting instruction must not write back.
    mem_wb_t wb_next;
    mem_wb_t wb_reg;

    always_comb begin
        wb_next            = '0;
        wb_next.reg_write  = in_RegWrite && !misaligned;
        wb_next.mem_to_reg = in_MemToReg;
        wb_next.dest       = in_writebackDestination;
        wb_next.mem_data   = load_result;
        wb_next.alu_result = in_aluResult;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk   (clk),
        .reset (reset),
        .d     (wb_next),
        .q     (wb_reg)
    );

    assign RegWrite_out             = wb_reg.reg_write;
    assign MemToReg_out             = wb_reg.mem_to_reg;
    assign writebackDestination_out = wb_reg.dest;
    assign memData_out              = wb_reg.mem_data;
    assign aluResult_out            = wb_reg.alu_result;

    // Sticky fault flag, cleared only by reset.
    logic fault_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_reg <= 1'b0;
        end else if (misaligned) begin
            fault_reg <= 1'b1;
        end
    end

    assign mem_fault = fault_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps followed by random
// transactions compared against a word-array reference model.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        in_RegWrite;
    logic        in_MemWrite;
    logic        in_MemRead;
    logic        in_MemToReg;
    logic        in_Branch;
    logic [1:0]  in_load_mode;
    logic        in_zero;
    logic [31:0] in_aluResult;
    logic [31:0] in_rt;
    logic [31:0] in_pc;
    logic [4:0]  in_writebackDestination;
    logic        PCSrc_out;
    logic [31:0] branch_pc_out;
    logic        RegWrite_out;
    logic        MemToReg_out;
    logic [4:0]  writebackDestination_out;
    logic [31:0] memData_out;
    logic [31:0] aluResult_out;
    logic        mem_fault;

    mem_stage dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_RegWrite              (in_RegWrite),
        .in_MemWrite              (in_MemWrite),
        .in_MemRead               (in_MemRead),
        .in_MemToReg              (in_MemToReg),
        .in_Branch                (in_Branch),
        .in_load_mode             (in_load_mode),
        .in_zero                  (in_zero),
        .in_aluResult             (in_aluResult),
        .in_rt                    (in_rt),
        .in_pc                    (in_pc),
        .in_writebackDestination  (in_writebackDestination),
        .PCSrc_out                (PCSrc_out),
        .branch_pc_out            (branch_pc_out),
        .RegWrite_out             (RegWrite_out),
        .MemToReg_out             (MemToReg_out),
        .writebackDestination_out (writebackDestination_out),
        .memData_out              (memData_out),
        .aluResult_out            (aluResult_out),
        .mem_fault                (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] model_mem [256];
    logic        model_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Big-endian sized load computed arithmetically from the word.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] mode);
        longint unsigned wv;
        longint          v;
        int unsigned     off;
        logic [31:0]     r;
        wv  = longint'(w);
        off = a % 4;
        case (mode)
            2'd0: v = longint'(wv);
            2'd1: begin
                v = longint'((wv >> (16 * (1 - off / 2))) % 65536);
                if (v >= 32768) v = v - 65536;
            end
            2'd2: begin
                v = longint'((wv >> (8 * (3 - off))) % 256);
                if (v >= 128) v = v - 256;
            end
            default: v = longint'((wv >> (8 * (3 - off))) % 256);
        endcase
        r = v[31:0];
        return r;
    endfunction

    function automatic logic model_mis(input logic [31:0] a, input logic [1:0] mode,
                                       input logic mr, input logic mw);
        int unsigned off;
        off = a % 4;
        if (mw && off != 0) return 1'b1;
        if (mr && mode == 2'd0 && off != 0) return 1'b1;
        if (mr && mode == 2'd1 && (off % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One EX/MEM transaction: drive, check branch outputs, clock, check MEM/WB.
    task automatic xact(input logic rw, input logic mw, input logic mr, input logic m2r,
                        input logic br, input logic z, input logic [1:0] mode,
                        input logic [31:0] alu, input logic [31:0] rt,
                        input logic [31:0] pc, input logic [4:0] dest);
        logic        mis;
        logic [31:0] exp_data;
        int unsigned idx;
        in_RegWrite             = rw;
        in_MemWrite             = mw;
        in_MemRead              = mr;
        in_MemToReg             = m2r;
        in_Branch               = br;
        in_zero                 = z;
        in_load_mode            = mode;
        in_aluResult            = alu;
        in_rt                   = rt;
        in_pc                   = pc;
        in_writebackDestination = dest;
        #1;
        chk("pcsrc", {31'd0, PCSrc_out}, {31'd0, br & z});
        chk("branch_pc", branch_pc_out, pc);
        idx      = (alu / 4) % 256;
        mis      = model_mis(alu, mode, mr, mw);
        exp_data = mis ? 32'd0 : model_load(model_mem[idx], alu, mode);
        @(posedge clk);
        #1;
        if (mw && !mis) model_mem[idx] = rt;
        if (mis) model_fault = 1'b1;
        chk("regwrite", {31'd0, RegWrite_out}, {31'd0, rw & ~mis});
        chk("memtoreg", {31'd0, MemToReg_out}, {31'd0, m2r});
        chk("dest", {27'd0, writebackDestination_out}, {27'd0, dest});
        chk("memdata", memData_out, exp_data);
        chk("aluresult", aluResult_out, alu);
        chk("fault", {31'd0, mem_fault}, {31'd0, model_fault});
        $display("txn rw=%0d mw=%0d mr=%0d mode=%0d addr=%h rt=%h -> data=%h rw_out=%0d fault=%0d",
                 rw, mw, mr, mode, alu, rt, memData_out, RegWrite_out, mem_fault);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_fault             = 1'b0;
        reset                   = 1'b1;
        in_RegWrite             = 1'b1;
        in_MemWrite             = 1'b0;
        in_MemRead              = 1'b0;
        in_MemToReg             = 1'b1;
        in_Branch               = 1'b1;
        in_zero                 = 1'b1;
        in_load_mode            = 2'd0;
        in_aluResult            = 32'h1234;
        in_rt                   = 32'd0;
        in_pc                   = 32'd0;
        in_writebackDestination = 5'd3;

        // Reset state, held across an edge
        @(posedge clk);
        #1;
        chk("rst_regwrite", {31'd0, RegWrite_out}, 32'd0);
        chk("rst_memtoreg", {31'd0, MemToReg_out}, 32'd0);
        chk("rst_dest", {27'd0, writebackDestination_out}, 32'd0);
        chk("rst_memdata", memData_out, 32'd0);
        chk("rst_alu", aluResult_out, 32'd0);
        chk("rst_fault", {31'd0, mem_fault}, 32'd0);
        chk("rst_pcsrc", {31'd0, PCSrc_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Give every word a known value
        for (int i = 0; i < 256; i++) begin
            xact(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'(i * 4), $urandom, 32'd0, 5'd0);
        end

        // Store then sized loads on word 0x10
        xact(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 32'h8001_7FFF, 32'd0, 5'd0);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 32'd0, 32'd0, 5'd4);
        chk("lw_10", memData_out, 32'h8001_7FFF);
        chk("lw_10_fault", {31'd0, mem_fault}, 32'd0);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h10, 32'd0, 32'd0, 5'd4);
        chk("lh_10", memData_out, 32'hFFFF_8001);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h12, 32'd0, 32'd0, 5'd4);
        chk("lh_12", memData_out, 32'h0000_7FFF);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h11, 32'd0, 32'd0, 5'd4);
        chk("lb_11", memData_out, 32'h0000_0001);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h10, 32'd0, 32'd0, 5'd4);
        chk("lb_10", memData_out, 32'hFFFF_FF80);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 32'h10, 32'd0, 32'd0, 5'd4);
        chk("lbu_10", memData_out, 32'h0000_0080);

        // Branch resolution
        xact(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0, 32'd0, 32'h40, 5'd0);
        xact(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'h44, 5'd0);

        // Read/write in the same cycle returns the old word
        xact(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 32'hCAFE_F00D, 32'd0, 5'd2);
        chk("rw_same_old", memData_out, 32'h8001_7FFF);
        xact(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 32'h8001_7FFF, 32'd0, 5'd0);

        // Misaligned store and load
        xact(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h13, 32'hDEAD_BEEF, 32'd0, 5'd0);
        chk("mis_sw_fault", {31'd0, mem_fault}, 32'd1);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 32'd0, 32'd0, 5'd4);
        chk("mis_sw_unchanged", memData_out, 32'h8001_7FFF);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h02, 32'd0, 32'd0, 5'd7);
        chk("mis_lw_regwrite", {31'd0, RegWrite_out}, 32'd0);
        chk("mis_lw_data", memData_out, 32'd0);
        chk("mis_fault_sticky", {31'd0, mem_fault}, 32'd1);

        // Wrap-around and pass-through latency
        xact(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h400, 32'h1234_5678, 32'd0, 5'd0);
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h000, 32'd0, 32'd0, 5'd9);
        chk("wrap_lw", memData_out, 32'h1234_5678);
        chk("pass_dest", {27'd0, writebackDestination_out}, 32'd9);

        // Asynchronous reset between edges
        xact(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'h20, 32'd0, 32'd0, 5'd5);
        chk("pre_rst_regwrite", {31'd0, RegWrite_out}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_regwrite", {31'd0, RegWrite_out}, 32'd0);
        chk("async_memtoreg", {31'd0, MemToReg_out}, 32'd0);
        chk("async_dest", {27'd0, writebackDestination_out}, 32'd0);
        chk("async_memdata", memData_out, 32'd0);
        chk("async_alu", aluResult_out, 32'd0);
        chk("async_fault", {31'd0, mem_fault}, 32'd0);
        chk("async_pcsrc", {31'd0, PCSrc_out}, 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        model_fault = 1'b0;
        xact(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 32'd0, 32'd0, 5'd4);
        chk("post_rst_mem", memData_out, 32'h8001_7FFF);

        // Random transactions against the model
        for (int n = 0; n < 300; n++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
            xact(1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 2'($urandom), addr, $urandom, $urandom,
                 5'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. It sits directly downstream of the execute stage and consumes that stage's EX/MEM register outputs.
- It contains the data memory: word-wide synchronous write, combinational read, and sized/sign-extended loads selected by load_mode.
- It resolves branches using the zero flag and the branch target PC.
- It owns the MEM/WB pipeline register that feeds write-back.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of two).
- ADDR_BITS, 8, log2(DEPTH); word index = address[ADDR_BITS+1:2].

Ports:
- clk  in  1  stage clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_RegWrite  in  1  write-back enable from EX/MEM
- in_MemWrite  in  1  store enable
- in_MemRead  in  1  load enable
- in_MemToReg  in  1  write-back source select (1 = memory data)
- in_Branch  in  1  instruction is a beq-type branch
- in_load_mode  in  2  00 lw, 01 lh (signed), 10 lb (signed), 11 lbu
- in_zero  in  1  ALU zero flag
- in_aluResult  in  32  ALU result / effective address
- in_rt  in  32  store data
- in_pc  in  32  branch target PC
- in_writebackDestination  in  5  destination register number
- PCSrc_out  out  1  combinational: in_Branch & in_zero & ~reset
- branch_pc_out  out  32  combinational copy of in_pc
- RegWrite_out  out  1  registered
- MemToReg_out  out  1  registered
- writebackDestination_out  out  5  registered
- memData_out  out  32  registered load result
- aluResult_out  out  32  registered in_aluResult
- mem_fault  out  1  sticky misaligned-access flag

Behaviour:
- Reset (asynchronous, active-high): RegWrite_out=0, MemToReg_out=0, writebackDestination_out=0, memData_out=0, aluResult_out=0, mem_fault=0. Memory contents are not reset. PCSrc_out=0 while reset is high.
- Byte order is big-endian. Byte offset 0 maps to word bits [31:24]. Halfword offset 0 maps to [31:16] and offset 2 to [15:0].
- Address alignment:
  - word access needs addr[1:0]=00
  - lh needs addr[0]=0
  - byte access is always aligned
- Stores write the full word only, regardless of load_mode. Write occurs at the rising edge when in_MemWrite=1, the access is aligned, and reset=0.
- Loads read combinationally from the array indexed by addr[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Load result by mode:
  - lw: the whole word
  - lh: the selected halfword, sign-extended
  - lb: the selected byte, sign-extended
  - lbu: the selected byte, zero-extended
- The load result is captured into memData_out at the next rising edge. Total load latency from EX/MEM outputs to memData_out is 1 cycle.
- Misaligned access (MemRead or MemWrite asserted with a misaligned address):
  - the store is suppressed
  - the load result is forced to 0
  - RegWrite for that instruction is forced to 0 in the MEM/WB register
  - mem_fault is set at the edge and stays set until reset
- If in_MemRead and in_MemWrite are both 1, the write takes priority. The same-cycle read returns the pre-write (old) array value.
- A load in the cycle after a store to the same word returns the new data; the array is written at the edge, so no forwarding is needed.
- When in_MemRead=0, memData_out still captures the combinational read. Write-back ignores it via MemToReg=0.
- MEM/WB register is a single stage with no stall or flush inputs. All registered outputs update every rising edge.

Decomposition:
- Shared package mips_pkg:
  - load_mode encodings LM_WORD=2'b00, LM_HALF=2'b01, LM_BYTE=2'b10, LM_BYTEU=2'b11
  - DATA_W=32, REG_ADDR_W=5
- Sub-module mem_wb_reg: the MEM/WB pipeline register with asynchronous reset.
- The data-memory array and load formatter stay inline in mem_stage.

Test Plan:
- Store then word load: MemWrite addr=0x10 rt=0x8001_7FFF, next cycle MemRead lw addr=0x10 → one edge later memData_out=0x80017FFF, mem_fault=0.
- Signed/unsigned sizes on that word:
  - lh addr 0x10 → 0xFFFF8001
  - lh addr 0x12 → 0x00007FFF
  - lb addr 0x11 → 0x00000001
  - lb addr 0x10 → 0xFFFFFF80
  - lbu addr 0x10 → 0x00000080
- Branch resolution: Branch=1 zero=1 pc=0x40 → PCSrc_out=1 and branch_pc_out=0x40 in the same cycle. Branch=1 zero=0 → PCSrc_out=0.
- Misaligned: sw addr=0x13 data=0xDEADBEEF → word 0x10 unchanged (still 0x80017FFF), mem_fault=1 after the edge. lw addr=0x02 with RegWrite=1 → RegWrite_out=0, memData_out=0. mem_fault stays 1 until reset.
- Wrap-around and pass-through: sw addr=0x400 (DEPTH=256) data=0x12345678, then lw addr=0x000 → 0x12345678. aluResult_out, MemToReg_out and writebackDestination_out (e.g. 5'd9) appear exactly 1 cycle after input.
- Reset mid-operation: assert reset asynchronously between edges while RegWrite_out=1 → all registered outputs go to 0 immediately without a clock edge, and PCSrc_out=0. After deassertion, earlier-stored memory data is still readable.
